// File: rtl/lsm_pkg.sv
// Shared state encoding and bus transfer-size codes for the load/store-multiple engine.
package lsm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MEMIO  = 2'd1,
        ST_BASEWB = 2'd2,
        ST_DONE   = 2'd3
    } lsm_state_e;

    localparam logic [2:0] SIZE_WORD  = 3'b100;
    localparam logic [2:0] SIZE_DWORD = 3'b101;

    function automatic logic [2:0] size_for_width(input int w);
        return (w == 64) ? SIZE_DWORD : SIZE_WORD;
    endfunction

endpackage

// File: rtl/lsm_if.sv
// Command, memory-bus, register-file and status signals of the LDM/STM engine.
interface lsm_if #(
    parameter int NREGS  = 16,
    parameter int DATA_W = 32
);
    localparam int RW = $clog2(NREGS);

    logic              start, flush;
    logic              load, up, pre, wb, usr;
    logic [RW-1:0]     base_num;
    logic [31:0]       base;
    logic [NREGS-1:0]  reglist;
    logic [31:0]       pc;

    logic [31:0]       busaddr;
    logic              rd_req, wr_req, rw_wait, bus_err;
    logic [DATA_W-1:0] wr_data, rd_data;
    logic [2:0]        data_size;

    logic [RW-1:0]     st_read;
    logic [DATA_W-1:0] st_data;
    logic              out_write_reg;
    logic [RW-1:0]     out_write_num;
    logic [DATA_W-1:0] out_write_data;

    logic              cpsr_from_spsr, outstall, busy, done, err;

    // Engine side: it masters the memory bus and the register write port.
    modport master (
        input  start, flush, load, up, pre, wb, usr, base_num, base, reglist, pc,
        input  rw_wait, bus_err, rd_data, st_data,
        output busaddr, rd_req, wr_req, wr_data, data_size, st_read,
        output out_write_reg, out_write_num, out_write_data,
        output cpsr_from_spsr, outstall, busy, done, err
    );

    modport slave (
        output start, flush, load, up, pre, wb, usr, base_num, base, reglist, pc,
        output rw_wait, bus_err, rd_data, st_data,
        input  busaddr, rd_req, wr_req, wr_data, data_size, st_read,
        input  out_write_reg, out_write_num, out_write_data,
        input  cpsr_from_spsr, outstall, busy, done, err
    );

endinterface

// File: rtl/lsm_prio_enc.sv
// Lowest-set-bit priority encoder; purely combinational.
module lsm_prio_enc #(
    parameter int NREGS = 16
) (
    input  logic [NREGS-1:0]         vec,
    output logic [$clog2(NREGS)-1:0] index,
    output logic                     valid
);
    localparam int RW = $clog2(NREGS);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        index = '0;
        valid = 1'b0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index = RW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lsm_engine.sv
// LDM/STM sequencer: one bus beat per listed register, optional base writeback, then a done pulse.
// Start to first request is 1 cycle; each beat stretches while rw_wait is high; upstream is stalled via outstall.
module lsm_engine #(
    parameter int NREGS  = 16,
    parameter int DATA_W = 32,
    parameter int PC_OFS = 12
) (
    input  logic  clk,
    input  logic  Nrst,
    lsm_if.master io
);
    import lsm_pkg::*;

    localparam int              RW     = $clog2(NREGS);
    localparam logic [31:0]     STRIDE = 32'(DATA_W / 8);
    localparam logic [RW-1:0]   PC_IDX = RW'(NREGS - 1);

    lsm_state_e        r_state, w_next;
    logic [NREGS-1:0]  r_mask, w_scan, w_rest;
    logic [RW-1:0]     r_base_num, w_idx, w_cur;
    logic [31:0]       r_base, r_pc, r_addr, w_wb_val, w_pre_ofs;
    logic [RW:0]       r_cnt;
    logic              r_load, r_up, r_wb, r_usr, r_base_in_list, r_err;
    logic              r_wr_vld, r_cpsr;
    logic [RW-1:0]     r_wr_num;
    logic [DATA_W-1:0] r_wr_dat;
    logic              w_vld, w_accept, w_beat_done;

    assign w_accept  = (r_state == ST_IDLE) && io.start && !io.flush;
    assign w_pre_ofs = io.pre ? STRIDE : 32'd0;

    // Descending transfers reuse the same encoder on a bit-reversed mask.
    always_comb begin
        w_scan = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_scan[i] = r_up ? r_mask[i] : r_mask[NREGS-1-i];
        end
    end

    lsm_prio_enc #(.NREGS(NREGS)) u_prio (
        .vec   (w_scan),
        .index (w_idx),
        .valid (w_vld)
    );

    assign w_cur       = r_up ? w_idx : PC_IDX - w_idx;
    assign w_rest      = r_mask & ~(NREGS'(1) << w_cur);
    assign w_beat_done = (r_state == ST_MEMIO) && w_vld && !io.rw_wait;
    assign w_wb_val    = r_up ? r_base + STRIDE * 32'(r_cnt) : r_base - STRIDE * 32'(r_cnt);

    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        io.outstall    = 1'b0;
        io.busy        = 1'b1;
        io.done        = 1'b0;
        io.err         = 1'b0;
        io.rd_req      = 1'b0;
        io.wr_req      = 1'b0;
        io.busaddr     = '0;
        io.data_size   = '0;
        io.st_read     = '0;
        io.wr_data     = '0;
        unique case (r_state)
            ST_IDLE: begin
                io.busy     = 1'b0;
                io.outstall = io.start && !io.flush;
                if (w_accept) w_next = (io.reglist == '0) ? ST_DONE : ST_MEMIO;
            end
            ST_MEMIO: begin
                io.outstall  = 1'b1;
                io.rd_req    = r_load;
                io.wr_req    = !r_load;
                io.busaddr   = r_addr;
                io.data_size = size_for_width(DATA_W);
                io.st_read   = w_cur;
                // The base register is stored as it was before this instruction.
                if (!r_load) begin
                    if (w_cur == PC_IDX)          io.wr_data = DATA_W'(r_pc + 32'(PC_OFS));
                    else if (w_cur == r_base_num) io.wr_data = DATA_W'(r_base);
                    else                          io.wr_data = io.st_data;
                end
                if (w_beat_done) begin
                    if (io.bus_err)       w_next = ST_DONE;
                    else if (w_rest == '0) w_next = r_wb ? ST_BASEWB : ST_DONE;
                end
            end
            ST_BASEWB: begin
                io.outstall = 1'b1;
                w_next      = ST_DONE;
            end
            ST_DONE: begin
                io.done = 1'b1;
                io.err  = r_err;
                w_next  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            r_mask         <= '0;
            r_cnt          <= '0;
            r_err          <= 1'b0;
            r_load         <= 1'b0;
            r_up           <= 1'b0;
            r_wb           <= 1'b0;
            r_usr          <= 1'b0;
            r_base_num     <= '0;
            r_base         <= '0;
            r_pc           <= '0;
            r_addr         <= '0;
            r_base_in_list <= 1'b0;
        end else if (w_accept) begin
            r_mask         <= io.reglist;
            r_cnt          <= '0;
            r_err          <= 1'b0;
            r_load         <= io.load;
            r_up           <= io.up;
            r_wb           <= io.wb;
            r_usr          <= io.usr;
            r_base_num     <= io.base_num;
            r_base         <= io.base;
            r_pc           <= io.pc;
            r_base_in_list <= io.reglist[io.base_num];
            r_addr         <= io.up ? io.base + w_pre_ofs : io.base - w_pre_ofs;
        end else if (w_beat_done) begin
            r_cnt  <= r_cnt + (RW+1)'(1);
            r_addr <= r_up ? r_addr + STRIDE : r_addr - STRIDE;
            // An abort empties the mask so nothing further is issued.
            if (io.bus_err) begin
                r_err  <= 1'b1;
                r_mask <= '0;
            end else begin
                r_mask <= w_rest;
            end
        end
    end

    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            r_wr_vld <= 1'b0;
            r_cpsr   <= 1'b0;
            r_wr_num <= '0;
            r_wr_dat <= '0;
        end else begin
            r_wr_vld <= 1'b0;
            r_cpsr   <= 1'b0;
            if (w_beat_done && r_load && !io.bus_err) begin
                r_wr_vld <= 1'b1;
                r_wr_num <= w_cur;
                r_wr_dat <= io.rd_data;
                r_cpsr   <= r_usr && (w_cur == PC_IDX);
            end else if ((r_state == ST_BASEWB) && !(r_load && r_base_in_list)) begin
                r_wr_vld <= 1'b1;
                r_wr_num <= r_base_num;
                r_wr_dat <= DATA_W'(w_wb_val);
            end
        end
    end

    assign io.out_write_reg  = r_wr_vld;
    assign io.out_write_num  = r_wr_num;
    assign io.out_write_data = r_wr_dat;
    assign io.cpsr_from_spsr = r_cpsr;

endmodule

// File: tb/tb_lsm_engine.sv
// Bench for lsm_engine: transaction-level model of beats and register writes, checked every cycle.
module tb_lsm_engine;

    logic clk = 1'b0;
    logic Nrst;
    always #5 clk = ~clk;

    lsm_if #(.NREGS(16), .DATA_W(32)) bus ();

    lsm_engine #(.NREGS(16), .DATA_W(32), .PC_OFS(12)) u_dut (
        .clk  (clk),
        .Nrst (Nrst),
        .io   (bus)
    );

    typedef struct { logic [31:0] addr; logic rd; logic [31:0] dat; } beat_t;
    typedef struct { logic [3:0] num; logic [31:0] dat; logic cpsr; } wrr_t;

    logic [31:0] regs [16];
    beat_t       exp_beats [$];
    wrr_t        exp_wrs [$];
    logic [31:0] log_addr [$];
    logic [31:0] log_dat [$];
    beat_t       cb;
    wrr_t        cw;
    int          n_chk = 0, n_pass = 0, n_wr_seen = 0, last_lat = 0;
    logic        exp_err = 1'b0, seen_err = 1'b0, prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;

    // Memory returns a fixed function of the address; register file follows the write port.
    assign bus.rd_data = bus.busaddr ^ 32'hDEAD_0000;
    assign bus.st_data = regs[bus.st_read];

    always @(posedge clk) begin
        if (!Nrst) begin
            for (int i = 0; i < 16; i++) regs[i] <= 32'h100 + 32'(i);
        end else if (bus.out_write_reg) begin
            regs[bus.out_write_num] <= bus.out_write_data;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_chk++;
        $display("FAIL %s: event occurred, want none", name);
    endtask

    // Expected beats, writes, error flag and start-to-done latency of one command.
    task automatic expect_cmd(input logic ld, input logic up, input logic pre, input logic wb,
                              input logic usr, input logic [3:0] bn, input logic [31:0] base,
                              input logic [15:0] rl, input logic [31:0] pc, input int wait_beat,
                              input int nwait, input int err_beat, output int lat);
        int          order [$];
        int          n, issued;
        logic        e;
        logic [31:0] a, off;
        beat_t       b;
        wrr_t        w;
        if (up) begin
            for (int i = 0; i < 16; i++) if (rl[i]) order.push_back(i);
        end else begin
            for (int i = 15; i >= 0; i--) if (rl[i]) order.push_back(i);
        end
        n      = order.size();
        e      = (err_beat >= 0) && (err_beat < n);
        issued = e ? err_beat + 1 : n;
        for (int k = 0; k < issued; k++) begin
            off    = 32'(4 * (k + int'(pre)));
            a      = up ? base + off : base - off;
            b.addr = a;
            b.rd   = ld;
            if (ld)                 b.dat = '0;
            else if (order[k] == 15) b.dat = pc + 32'd12;
            else if (order[k] == int'(bn)) b.dat = base;
            else                    b.dat = regs[order[k]];
            exp_beats.push_back(b);
            if (ld && !(e && k == err_beat)) begin
                w.num  = 4'(order[k]);
                w.dat  = a ^ 32'hDEAD_0000;
                w.cpsr = usr && (order[k] == 15);
                exp_wrs.push_back(w);
            end
        end
        if (wb && !e && n > 0 && !(ld && rl[bn])) begin
            w.num  = bn;
            w.dat  = up ? base + 32'(4 * n) : base - 32'(4 * n);
            w.cpsr = 1'b0;
            exp_wrs.push_back(w);
        end
        exp_err = e;
        lat = issued + ((nwait > 0 && wait_beat < issued) ? nwait : 0)
                     + ((wb && !e && n > 0) ? 1 : 0) + 1;
    endtask

    task automatic run_cmd(input logic ld, input logic up, input logic pre, input logic wb,
                           input logic usr, input logic [3:0] bn, input logic [31:0] base,
                           input logic [15:0] rl, input logic [31:0] pc, input int wait_beat,
                           input int nwait, input int err_beat, input string tag);
        int lat, beat, waits, c;
        expect_cmd(ld, up, pre, wb, usr, bn, base, rl, pc, wait_beat, nwait, err_beat, lat);
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b0; bus.load = ld; bus.up = up; bus.pre = pre;
        bus.wb = wb; bus.usr = usr; bus.base_num = bn; bus.base = base; bus.reglist = rl;
        bus.pc = pc;
        beat = 0; waits = nwait; c = 0;
        while (c < 200) begin
            @(negedge clk);
            c++;
            bus.start   = 1'b0;
            bus.rw_wait = 1'b0;
            bus.bus_err = 1'b0;
            if (bus.done) break;
            if (bus.rd_req || bus.wr_req) begin
                if (beat == wait_beat && waits > 0) begin
                    bus.rw_wait = 1'b1;
                    waits--;
                end else begin
                    bus.bus_err = (beat == err_beat);
                    beat++;
                end
            end
        end
        last_lat = c;
        check({tag, "_latency"}, 64'(c), 64'(lat));
        @(negedge clk);
        #3;
        check({tag, "_beats_left"}, 64'(exp_beats.size()), 0);
        check({tag, "_writes_left"}, 64'(exp_wrs.size()), 0);
    endtask

    always @(negedge clk) begin
        #2;
        if (Nrst) begin
            if (bus.rd_req || bus.wr_req) begin
                check("one_req", 64'(bus.rd_req ^ bus.wr_req), 1);
                check("data_size", 64'(bus.data_size), 64'(3'b100));
                if (prev_wait) check("addr_hold", 64'(bus.busaddr), 64'(prev_addr));
                if (!bus.rw_wait) begin
                    log_addr.push_back(bus.busaddr);
                    log_dat.push_back(bus.wr_data);
                    if (exp_beats.size() == 0) begin
                        fail("extra_beat");
                    end else begin
                        cb = exp_beats.pop_front();
                        check("beat_addr", 64'(bus.busaddr), 64'(cb.addr));
                        check("beat_dir", 64'(bus.rd_req), 64'(cb.rd));
                        if (!cb.rd) check("beat_wdata", 64'(bus.wr_data), 64'(cb.dat));
                    end
                end
                prev_wait = bus.rw_wait;
                prev_addr = bus.busaddr;
            end else begin
                prev_wait = 1'b0;
                if (!bus.busy) check("idle_bus", {bus.busaddr, bus.wr_data}, 0);
            end
            check("outstall", 64'(bus.outstall),
                  64'((bus.busy && !bus.done) || (!bus.busy && bus.start && !bus.flush)));
            if (bus.out_write_reg) begin
                n_wr_seen++;
                if (exp_wrs.size() == 0) begin
                    fail("extra_write");
                end else begin
                    cw = exp_wrs.pop_front();
                    check("wr_num", 64'(bus.out_write_num), 64'(cw.num));
                    check("wr_data", 64'(bus.out_write_data), 64'(cw.dat));
                    check("wr_cpsr", 64'(bus.cpsr_from_spsr), 64'(cw.cpsr));
                end
            end else begin
                check("cpsr_quiet", 64'(bus.cpsr_from_spsr), 0);
            end
            if (bus.done) begin
                check("done_err", 64'(bus.err), 64'(exp_err));
                seen_err = bus.err;
            end
        end else begin
            prev_wait = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Nrst = 1'b0;
        bus.start = 1'b0; bus.flush = 1'b0; bus.load = 1'b0; bus.up = 1'b0; bus.pre = 1'b0;
        bus.wb = 1'b0; bus.usr = 1'b0; bus.base_num = '0; bus.base = '0; bus.reglist = '0;
        bus.pc = '0; bus.rw_wait = 1'b0; bus.bus_err = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        check("rst_busy", 64'(bus.busy), 0);
        check("rst_reqs", 64'({bus.rd_req, bus.wr_req}), 0);
        check("rst_done_err", 64'({bus.done, bus.err}), 0);
        check("rst_write_cpsr", 64'({bus.out_write_reg, bus.cpsr_from_spsr}), 0);
        Nrst = 1'b1;
        @(negedge clk);

        // LDMIA r13!, {r0,r1,r4}
        run_cmd(1, 1, 0, 1, 0, 4'd13, 32'h1000, 16'h0013, 32'h0, -1, 0, -1, "ldmia");
        check("ldmia_lat5", 64'(last_lat), 5);
        check("ldmia_r0", 64'(regs[0]), 64'(32'hDEAD_1000));
        check("ldmia_r1", 64'(regs[1]), 64'(32'hDEAD_1004));
        check("ldmia_r4", 64'(regs[4]), 64'(32'hDEAD_1008));
        check("ldmia_base", 64'(regs[13]), 64'(32'h100C));

        // STMDB r13, {r0,pc}
        log_addr.delete(); log_dat.delete();
        run_cmd(0, 0, 1, 0, 0, 4'd13, 32'h2000, 16'h8001, 32'h40, -1, 0, -1, "stmdb");
        check("stmdb_a0", 64'(log_addr[0]), 64'(32'h1FFC));
        check("stmdb_d0", 64'(log_dat[0]), 64'(32'h4C));
        check("stmdb_a1", 64'(log_addr[1]), 64'(32'h1FF8));
        check("stmdb_d1", 64'(log_dat[1]), 64'(32'hDEAD_1000));

        // Three wait cycles on the second beat
        n_wr_seen = 0;
        run_cmd(1, 1, 0, 0, 0, 4'd9, 32'h3000, 16'h00E0, 32'h0, 1, 3, -1, "wait");
        check("wait_lat7", 64'(last_lat), 7);
        check("wait_writes", 64'(n_wr_seen), 3);

        // Base in list on a load: loaded value wins over writeback
        run_cmd(1, 1, 0, 1, 0, 4'd2, 32'h1000, 16'h0006, 32'h0, -1, 0, -1, "baseld");
        check("baseld_r2", 64'(regs[2]), 64'(32'hDEAD_1004));

        // Abort on the second of four beats
        n_wr_seen = 0;
        run_cmd(1, 1, 0, 1, 0, 4'd12, 32'h4000, 16'h0F00, 32'h0, -1, 0, 1, "abort");
        check("abort_writes", 64'(n_wr_seen), 1);
        check("abort_err", 64'(seen_err), 1);
        check("abort_no_wb", 64'(regs[12]), 64'(32'h10C));

        // LDMIB with S bit and PC in list
        run_cmd(1, 1, 1, 1, 1, 4'd3, 32'h5000, 16'h8000, 32'h0, -1, 0, -1, "ldmpc");
        check("ldmpc_pc", 64'(regs[15]), 64'(32'hDEAD_5004));
        check("ldmpc_wb", 64'(regs[3]), 64'(32'h5004));

        // STMIA with base in list stores the original base
        log_addr.delete(); log_dat.delete();
        run_cmd(0, 1, 0, 1, 0, 4'd4, 32'h6000, 16'h0011, 32'h0, -1, 0, -1, "stmbase");
        check("stmbase_d1", 64'(log_dat[1]), 64'(32'h6000));
        check("stmbase_wb", 64'(regs[4]), 64'(32'h6008));

        // Empty list goes straight to done
        run_cmd(1, 1, 0, 1, 0, 4'd5, 32'h7000, 16'h0000, 32'h0, -1, 0, -1, "empty");
        check("empty_lat1", 64'(last_lat), 1);

        // start with flush is ignored
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.load = 1'b1; bus.reglist = 16'h0001;
        #3;
        check("flush_outstall", 64'(bus.outstall), 0);
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3;
            check("flush_idle", 64'({bus.busy, bus.rd_req, bus.wr_req}), 0);
            @(negedge clk);
        end

        // Reset in the middle of a stalled beat
        bus.start = 1'b1; bus.load = 1'b1; bus.up = 1'b1; bus.pre = 1'b0; bus.wb = 1'b1;
        bus.base_num = 4'd6; bus.base = 32'h8000; bus.reglist = 16'h0003; bus.rw_wait = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        #3;
        check("rstmid_req", 64'(bus.rd_req), 1);
        Nrst = 1'b0;
        #1;
        check("rstmid_busy", 64'(bus.busy), 0);
        check("rstmid_noreq", 64'(bus.rd_req), 0);
        bus.rw_wait = 1'b0;
        @(negedge clk);
        Nrst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #3;
            check("rstmid_quiet", 64'({bus.busy, bus.rd_req, bus.wr_req}), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
